keypad_encoder: RTL and testbench
=================================

// Module: keypad_encoder
// PURPOSE
//  Scans a 4-row x 5-column key matrix, debounces it and emits one-cycle key events
//  (newhex/hexcode, newop/opcode, eq, BS) for the calculator register block.
//  Sits between the board keypad pins and the register block. Exactly one event per physical press.
// PARAMETERS
//  SCAN_DIV         1000    clocks each column is driven before its rows are sampled (>=4)
//  DEBOUNCE_CYCLES  250000  consecutive stable clocks needed to accept a press or a release (>=2)
// PORTS
//  clock    in   1  system clock
//  reset    in   1  asynchronous, active-high reset
//  row      in   4  keypad rows, active-low, pulled up, asynchronous to clock
//  col      out  5  column drive, one-hot active-low (exactly one bit 0 at all times)
//  newhex   out  1  one-cycle pulse: hex key 0-F accepted
//  hexcode  out  4  value of last hex key; valid while newhex=1, held until next hex key
//  newop    out  1  one-cycle pulse: operator key accepted
//  opcode   out  2  0=add, 1=subtract; valid while newop=1, held until next operator
//  eq       out  1  one-cycle pulse: equals key accepted
//  BS       out  1  one-cycle pulse: backspace key accepted
//  key_held out  1  high from press acceptance until release is accepted
// BEHAVIOUR
//  Reset: col=5'b11110, newhex/newop/eq/BS/key_held=0, hexcode=0, opcode=0, state=SCAN,
//   counters=0, row synchroniser flops=4'b1111. Reset mid-press aborts; no event is emitted.
//  row passes a 2-flop synchroniser (rs); all decisions use rs only.
//  Key map: col c=0..3, row r=0..3 -> hex key, hexcode = 4*r + c.
//   col 4: r0 = op add (opcode 0), r1 = op subtract (opcode 1), r2 = eq, r3 = BS.
//  Several rows low in one column: lowest row index wins. Other columns ignored while not SCAN.
//  FSM:
//   SCAN: drive col[cidx] low for SCAN_DIV clocks. On the last clock of the dwell, sample rs.
//    If any bit is 0: capture the row index and go to DEBOUNCE with the column held.
//    Otherwise advance cidx (4 wraps to 0) and restart the dwell.
//   DEBOUNCE: each clock, check that rs still shows the captured row as lowest active.
//    Mismatch or no key: return to SCAN on the same column with dwell restarted.
//    DEBOUNCE_CYCLES consecutive matching clocks: go to PRESSED.
//   PRESSED: the event pulse is registered high for exactly the first clock in PRESSED.
//    hexcode/opcode update on that same clock. key_held goes to 1.
//    Stays in PRESSED while any rs bit is 0. When rs=4'b1111, go to RELEASE.
//   RELEASE: count consecutive rs=4'b1111 clocks; any low bit restarts the count (no new event).
//    At DEBOUNCE_CYCLES: key_held=0, advance cidx, go to SCAN.
//  Holding a key gives exactly one event; there is no auto-repeat.
//  At most one of newhex/newop/eq/BS is high in any cycle.
//  Latency: from rows stable-low at a sampled dwell end, the pulse comes 2 (sync) + 1 + DEBOUNCE_CYCLES clocks later, +/-1.
//  Counter widths come from $clog2 of the parameters. Counters saturate and never wrap.
// TESTING  (bench keypad model: row[r]=0 iff key(r,c) pressed and col[c]=0; SCAN_DIV=4, DEBOUNCE_CYCLES=8)
//  1 Press key (r2,c3) clean, hold 40 clk, release -> one newhex pulse, hexcode=4'hB, key_held high then low.
//  2 Press (r1,c4) with 5 clk of 1-clk bounce glitches, then stable -> one newop, opcode=1; no pulse during bounce.
//  3 Press (r2,c4), then (r3,c4) -> one eq pulse, then one BS pulse. Released between presses for >=8 clk.
//  4 Hold (r0,c1) 200 clk with release bounce of 3 clk -> exactly one newhex, hexcode=1. No second event after bounce.
//  5 Press (r0,c2)+(r3,c2) together -> single newhex, hexcode=2 (lowest row wins).
//  6 Assert reset during DEBOUNCE of (r1,c0) -> col=5'b11110, no pulse. After reset, held key yields hexcode=4.

Source files
------------

// File: rtl/keypad_encoder_if.sv
// ============================================================================
// keypad_encoder_if : keypad pins and calculator key-event bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface keypad_encoder_if;
  logic [3:0] row;
  logic [4:0] col;
  logic       newhex;
  logic [3:0] hexcode;
  logic       newop;
  logic [1:0] opcode;
  logic       eq;
  logic       BS;
  logic       key_held;

  modport master (
    input  row,
    output col, newhex, hexcode, newop, opcode, eq, BS, key_held
  );

  modport slave (
    output row,
    input  col, newhex, hexcode, newop, opcode, eq, BS, key_held
  );
endinterface

`default_nettype wire

// File: rtl/keypad_encoder.sv
// ============================================================================
// keypad_encoder : scans a 4x5 key matrix, debounces, emits one event per press
// Revision 1.0
// ============================================================================
`default_nettype none

module keypad_encoder #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  wire logic         clock,
  input  wire logic         reset,
  keypad_encoder_if.master  kp
);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       rs1_q, rs_q;
  logic [2:0]       cidx_q, cidx_d;
  logic [1:0]       rowi_q, rowi_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic             newhex_q, newhex_d, newop_q, newop_d, eq_q, eq_d, bs_q, bs_d;
  logic             held_q, held_d;
  logic [3:0]       hexcode_q, hexcode_d;
  logic [1:0]       opcode_q, opcode_d;

  logic [1:0] lowest;
  logic       any_low;
  logic [2:0] cidx_next;

  // Lowest active row index wins when several rows are low
  always_comb begin
    lowest = 2'd3;
    if (!rs_q[0])      lowest = 2'd0;
    else if (!rs_q[1]) lowest = 2'd1;
    else if (!rs_q[2]) lowest = 2'd2;
  end

  assign any_low   = (rs_q != 4'b1111);
  assign cidx_next = (cidx_q == 3'd4) ? 3'd0 : cidx_q + 3'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rs1_q     <= 4'b1111;
      rs_q      <= 4'b1111;
      state_q   <= SCAN;
      cidx_q    <= 3'd0;
      rowi_q    <= 2'd0;
      div_q     <= '0;
      deb_q     <= '0;
      newhex_q  <= 1'b0;
      newop_q   <= 1'b0;
      eq_q      <= 1'b0;
      bs_q      <= 1'b0;
      held_q    <= 1'b0;
      hexcode_q <= 4'd0;
      opcode_q  <= 2'd0;
    end else begin
      rs1_q     <= kp.row;
      rs_q      <= rs1_q;
      state_q   <= state_d;
      cidx_q    <= cidx_d;
      rowi_q    <= rowi_d;
      div_q     <= div_d;
      deb_q     <= deb_d;
      newhex_q  <= newhex_d;
      newop_q   <= newop_d;
      eq_q      <= eq_d;
      bs_q      <= bs_d;
      held_q    <= held_d;
      hexcode_q <= hexcode_d;
      opcode_q  <= opcode_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cidx_d    = cidx_q;
    rowi_d    = rowi_q;
    div_d     = div_q;
    deb_d     = deb_q;
    newhex_d  = 1'b0;
    newop_d   = 1'b0;
    eq_d      = 1'b0;
    bs_d      = 1'b0;
    held_d    = held_q;
    hexcode_d = hexcode_q;
    opcode_d  = opcode_q;

    unique case (state_q)
      SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          deb_d = '0;
          if (any_low) begin
            rowi_d  = lowest;
            state_d = DEBOUNCE;
          end else begin
            cidx_d = cidx_next;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (!any_low || (lowest != rowi_q)) begin
          state_d = SCAN;
          div_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          // Pulse is registered so it is high on the first PRESSED clock
          state_d = PRESSED;
          held_d  = 1'b1;
          if (cidx_q == 3'd4) begin
            unique case (rowi_q)
              2'd0: begin newop_d = 1'b1; opcode_d = 2'd0; end
              2'd1: begin newop_d = 1'b1; opcode_d = 2'd1; end
              2'd2: eq_d = 1'b1;
              default: bs_d = 1'b1;
            endcase
          end else begin
            newhex_d  = 1'b1;
            hexcode_d = {rowi_q, cidx_q[1:0]};
          end
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end

      PRESSED: begin
        if (!any_low) begin
          state_d = RELEASE;
          deb_d   = '0;
        end
      end

      default: begin
        if (any_low) begin
          deb_d = '0;
        end else if (deb_q == DEB_LAST) begin
          held_d  = 1'b0;
          cidx_d  = cidx_next;
          div_d   = '0;
          state_d = SCAN;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    kp.col = 5'b11111;
    unique case (cidx_q)
      3'd0:    kp.col = 5'b11110;
      3'd1:    kp.col = 5'b11101;
      3'd2:    kp.col = 5'b11011;
      3'd3:    kp.col = 5'b10111;
      default: kp.col = 5'b01111;
    endcase
  end

  assign kp.newhex   = newhex_q;
  assign kp.hexcode  = hexcode_q;
  assign kp.newop    = newop_q;
  assign kp.opcode   = opcode_q;
  assign kp.eq       = eq_q;
  assign kp.BS       = bs_q;
  assign kp.key_held = held_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_encoder.sv
// ============================================================================
// tb_keypad_encoder : keypad matrix model with queued expected key events
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_keypad_encoder;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam logic [1:0] K_HEX = 2'd0, K_OP = 2'd1, K_EQ = 2'd2, K_BS = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic keys [4][5];
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [5:0] exp_q [$];

  keypad_encoder_if kp ();

  keypad_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clock (clk),
    .reset (rst),
    .kp    (kp.master)
  );

  always #5 clk = ~clk;

  // A row reads low when a pressed key sits on the currently driven column
  always_comb begin
    kp.row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        if (keys[r][c] && !kp.col[c]) kp.row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++) keys[r][c] = 1'b0;
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [3:0] code);
    exp_q.push_back({kind, code});
  endtask

  task automatic wait_held(input logic v, input string name);
    for (int i = 0; i < 300; i++) begin
      if (kp.key_held === v) break;
      @(negedge clk);
    end
    check(name, {31'd0, kp.key_held}, {31'd0, v});
  endtask

  task automatic wait_col(input logic [4:0] c, input string name);
    for (int i = 0; i < 200; i++) begin
      if (kp.col === c) break;
      @(negedge clk);
    end
    check(name, {27'd0, kp.col}, {27'd0, c});
  endtask

  // Monitor: every pulse must match the head of the expected-event queue
  always @(negedge clk) begin
    if (!rst) begin
      int npulse;
      logic [1:0] kind;
      logic [3:0] code;
      logic [5:0] e;
      npulse = int'(kp.newhex) + int'(kp.newop) + int'(kp.eq) + int'(kp.BS);
      if (npulse > 1) check("onehot_pulse", npulse, 1);
      if (npulse != 0) begin
        kind = kp.newhex ? K_HEX : kp.newop ? K_OP : kp.eq ? K_EQ : K_BS;
        code = kp.newhex ? kp.hexcode : kp.newop ? {2'b00, kp.opcode} : 4'd0;
        if (exp_q.size() == 0) begin
          check("unexpected_event", {26'd0, kind, code}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("event", {26'd0, kind, code}, {26'd0, e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_keys();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_col", {27'd0, kp.col}, 32'h1E);
    check("rst_held", {31'd0, kp.key_held}, 0);
    check("rst_pulses", {28'd0, kp.newhex, kp.newop, kp.eq, kp.BS}, 0);
    check("rst_codes", {26'd0, kp.hexcode, kp.opcode}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: clean press of (r2,c3)
    keys[2][3] = 1'b1;
    expect_ev(K_HEX, 4'hB);
    repeat (40) @(negedge clk);
    check("t1_held", {31'd0, kp.key_held}, 1);
    clear_keys();
    wait_held(1'b0, "t1_release");
    repeat (10) @(negedge clk);

    // 2: bouncy press of (r1,c4)
    for (int i = 0; i < 5; i++) begin
      keys[1][4] = (i % 2 == 0);
      @(negedge clk);
    end
    keys[1][4] = 1'b1;
    expect_ev(K_OP, 4'd1);
    wait_held(1'b1, "t2_held");
    clear_keys();
    wait_held(1'b0, "t2_release");
    repeat (10) @(negedge clk);

    // 3: equals then backspace
    keys[2][4] = 1'b1;
    expect_ev(K_EQ, 4'd0);
    wait_held(1'b1, "t3_eq_held");
    clear_keys();
    wait_held(1'b0, "t3_eq_release");
    repeat (10) @(negedge clk);
    keys[3][4] = 1'b1;
    expect_ev(K_BS, 4'd0);
    wait_held(1'b1, "t3_bs_held");
    clear_keys();
    wait_held(1'b0, "t3_bs_release");
    repeat (10) @(negedge clk);

    // 4: long hold of (r0,c1) with release bounce
    keys[0][1] = 1'b1;
    expect_ev(K_HEX, 4'd1);
    repeat (200) @(negedge clk);
    check("t4_held", {31'd0, kp.key_held}, 1);
    for (int i = 0; i < 3; i++) begin
      keys[0][1] = (i == 1);
      @(negedge clk);
    end
    keys[0][1] = 1'b0;
    wait_held(1'b0, "t4_release");
    repeat (30) @(negedge clk);

    // 5: two rows in column 2, lowest row wins
    keys[0][2] = 1'b1;
    keys[3][2] = 1'b1;
    expect_ev(K_HEX, 4'd2);
    wait_held(1'b1, "t5_held");
    clear_keys();
    wait_held(1'b0, "t5_release");
    repeat (10) @(negedge clk);

    // 6: reset during debounce of (r1,c0)
    wait_col(5'b11101, "t6_col1");
    keys[1][0] = 1'b1;
    wait_col(5'b11110, "t6_col0");
    repeat (SCAN_DIV + 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_col", {27'd0, kp.col}, 32'h1E);
    check("t6_rst_held", {31'd0, kp.key_held}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_ev(K_HEX, 4'd4);
    wait_held(1'b1, "t6_held");
    clear_keys();
    wait_held(1'b0, "t6_release");
    repeat (20) @(negedge clk);

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
